// File: rtl/isa_data_port_width_adapter.sv
// ISA data-port width adapter.
// Bridges synchronised ISA IOR#/IOW# strobes to a single-word internal port.
// In 16-bit AT mode whole words move per ISA cycle and IOCS16# is driven.
// In 8-bit XT mode byte writes are paired into words and word reads are split
// into two byte reads. Protocol errors are kept in sticky flags. IOCHRDY
// throttles the bus while the write output register is full.
module isa_data_port_width_adapter #(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter logic [7:0]  FILL_BYTE      = 8'hFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        detection_valid,
  input  logic        enable_high_byte,
  input  logic        isa_addr_hit,
  input  logic        isa_wr_strobe,
  input  logic        isa_rd_strobe,
  input  logic        isa_a0,
  input  logic        isa_sbhe_n,
  input  logic [15:0] isa_wdata,
  output logic [15:0] isa_rdata,
  output logic        iocs16_n,
  output logic        isa_chrdy,
  output logic [15:0] wr_word,
  output logic        wr_valid,
  input  logic        wr_ready,
  input  logic [15:0] rd_word,
  input  logic        rd_valid,
  output logic        rd_pop,
  input  logic        err_clr,
  output logic [2:0]  err_flags
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WR_LOW  = 2'd1,
    S_RD_HIGH = 2'd2
  } state_t;

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d, st_eff;
  logic             word_mode_q;
  logic [7:0]       hold_q, hold_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      rdata_d, wr_word_d, complete_word;
  logic             wr_valid_d, rd_pop_d, complete, word_cycle;
  logic [2:0]       err_set;

  // Full 16-bit transfer: word mode with both byte lanes enabled.
  assign word_cycle = word_mode_q & ~isa_a0 & ~isa_sbhe_n;

  // Stall the ISA cycle while the output word waits for the internal port.
  assign isa_chrdy = ~(wr_valid & ~wr_ready);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state, datapath next values and error events for this cycle.
  always_comb begin
    state_d       = state_q;
    st_eff        = state_q;
    hold_d        = hold_q;
    cnt_d         = '0;
    rdata_d       = isa_rdata;
    wr_word_d     = wr_word;
    wr_valid_d    = wr_valid & ~wr_ready;
    rd_pop_d      = 1'b0;
    err_set       = '0;
    complete      = 1'b0;
    complete_word = '0;

    if (isa_wr_strobe) begin
      // A write abandons any held read byte before being decoded.
      if (state_q == S_RD_HIGH) st_eff = S_IDLE;
      state_d = st_eff;
      if (isa_rd_strobe) err_set[1] = 1'b1;

      if (word_cycle) begin
        if (st_eff == S_WR_LOW) err_set[0] = 1'b1;
        complete      = 1'b1;
        complete_word = isa_wdata;
        state_d       = S_IDLE;
      end else if (!isa_a0) begin
        if (st_eff == S_WR_LOW) err_set[0] = 1'b1;
        hold_d  = isa_wdata[7:0];
        state_d = S_WR_LOW;
      end else if (st_eff == S_WR_LOW) begin
        complete      = 1'b1;
        complete_word = {word_mode_q ? isa_wdata[15:8] : isa_wdata[7:0], hold_q};
        state_d       = S_IDLE;
      end else begin
        err_set[0] = 1'b1;
      end

      if (complete) begin
        if (wr_valid && !wr_ready) begin
          err_set[1] = 1'b1;
        end else begin
          wr_word_d  = complete_word;
          wr_valid_d = 1'b1;
        end
      end
    end else if (isa_rd_strobe) begin
      if (!isa_a0) begin
        if (!rd_valid) begin
          rdata_d    = {FILL_BYTE, FILL_BYTE};
          err_set[2] = 1'b1;
        end else begin
          rd_pop_d = 1'b1;
          if (word_cycle) begin
            rdata_d = rd_word;
            if (state_q == S_RD_HIGH) state_d = S_IDLE;
          end else begin
            rdata_d = {8'h00, rd_word[7:0]};
            hold_d  = rd_word[15:8];
            state_d = S_RD_HIGH;
          end
        end
      end else if (state_q == S_RD_HIGH) begin
        rdata_d = {8'h00, hold_q};
        state_d = S_IDLE;
      end else begin
        rdata_d    = {8'h00, FILL_BYTE};
        err_set[0] = 1'b1;
      end
    end else if (state_q != S_IDLE) begin
      if (cnt_q == TIMEOUT_LAST) begin
        state_d    = S_IDLE;
        err_set[0] = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Datapath, mode, IOCS16# and sticky error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_mode_q <= 1'b0;
      hold_q      <= '0;
      cnt_q       <= '0;
      isa_rdata   <= 16'hFFFF;
      iocs16_n    <= 1'b1;
      wr_word     <= '0;
      wr_valid    <= 1'b0;
      rd_pop      <= 1'b0;
      err_flags   <= '0;
    end else begin
      if (state_q == S_IDLE) word_mode_q <= enable_high_byte & detection_valid;
      hold_q    <= hold_d;
      cnt_q     <= cnt_d;
      isa_rdata <= rdata_d;
      iocs16_n  <= ~(word_mode_q & isa_addr_hit);
      wr_word   <= wr_word_d;
      wr_valid  <= wr_valid_d;
      rd_pop    <= rd_pop_d;
      err_flags <= (err_flags & ~{3{err_clr}}) | err_set;
    end
  end

endmodule
